// File: rtl/minmax_pipe.sv
// rtl/minmax_pipe.sv - pipelined min/max/argmin/argmax/range finder with valid/ready flow control
module minmax_pipe #(
  parameter  int WIDTH    = 10,
  parameter  int CHANNELS = 3,
  parameter  int USER_W   = 3,
  localparam int IDX_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1,
  localparam int LEVELS   = $clog2(CHANNELS),
  localparam int LATENCY  = LEVELS + 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [USER_W-1:0]         in_user,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_min,
  output logic [IDX_W-1:0]          out_min_idx,
  output logic [WIDTH-1:0]          out_max,
  output logic [IDX_W-1:0]          out_max_idx,
  output logic [WIDTH-1:0]          out_range,
  output logic [USER_W-1:0]         out_user,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Number of tree nodes alive at a given level; odd nodes round up and pass through.
  function automatic int node_cnt(input int lvl_n);
    int n;
    n = CHANNELS;
    for (int i = 0; i < lvl_n; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // One global enable: the whole pipe freezes only when the output is held.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic [LATENCY-1:0] vld;
  logic [USER_W-1:0]  usr [LATENCY];

  // Valid bits and sideband shift together so every stage stays aligned with its beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < LATENCY; i++) usr[i] <= '0;
    end else if (en) begin
      vld    <= {vld[LATENCY-2:0], in_valid};
      usr[0] <= in_user;
      for (int i = 1; i < LATENCY; i++) usr[i] <= usr[i-1];
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_user  = usr[LATENCY-1];

  // Level 0 is the input register; levels 1..LEVELS are the comparator tree.
  for (genvar l = 0; l <= LEVELS; l++) begin : lvl
    for (genvar j = 0; j < node_cnt(l); j++) begin : nd
      logic [WIDTH-1:0] mnv, mxv;
      logic [IDX_W-1:0] mni, mxi;

      if (l == 0) begin : g_in
        // Each channel becomes a leaf tagged with its own index.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            mnv <= '0; mni <= '0; mxv <= '0; mxi <= '0;
          end else if (en) begin
            mnv <= in_data[j*WIDTH +: WIDTH];
            mni <= IDX_W'(j);
            mxv <= in_data[j*WIDTH +: WIDTH];
            mxi <= IDX_W'(j);
          end
        end
      end else if (2*j + 1 < node_cnt(l-1)) begin : g_pair
        // Right operand wins only when strictly better, so ties keep the lower channel.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            mnv <= '0; mni <= '0; mxv <= '0; mxi <= '0;
          end else if (en) begin
            if (lvl[l-1].nd[2*j+1].mnv < lvl[l-1].nd[2*j].mnv) begin
              mnv <= lvl[l-1].nd[2*j+1].mnv;
              mni <= lvl[l-1].nd[2*j+1].mni;
            end else begin
              mnv <= lvl[l-1].nd[2*j].mnv;
              mni <= lvl[l-1].nd[2*j].mni;
            end
            if (lvl[l-1].nd[2*j+1].mxv > lvl[l-1].nd[2*j].mxv) begin
              mxv <= lvl[l-1].nd[2*j+1].mxv;
              mxi <= lvl[l-1].nd[2*j+1].mxi;
            end else begin
              mxv <= lvl[l-1].nd[2*j].mxv;
              mxi <= lvl[l-1].nd[2*j].mxi;
            end
          end
        end
      end else begin : g_pass
        // Unpaired odd node is carried forward unchanged to keep level timing uniform.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            mnv <= '0; mni <= '0; mxv <= '0; mxi <= '0;
          end else if (en) begin
            mnv <= lvl[l-1].nd[2*j].mnv;
            mni <= lvl[l-1].nd[2*j].mni;
            mxv <= lvl[l-1].nd[2*j].mxv;
            mxi <= lvl[l-1].nd[2*j].mxi;
          end
        end
      end
    end
  end

  // Final stage: register results and range; max >= min so the difference never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_min     <= '0;
      out_min_idx <= '0;
      out_max     <= '0;
      out_max_idx <= '0;
      out_range   <= '0;
    end else if (en) begin
      out_min     <= lvl[LEVELS].nd[0].mnv;
      out_min_idx <= lvl[LEVELS].nd[0].mni;
      out_max     <= lvl[LEVELS].nd[0].mxv;
      out_max_idx <= lvl[LEVELS].nd[0].mxi;
      out_range   <= lvl[LEVELS].nd[0].mxv - lvl[LEVELS].nd[0].mnv;
    end
  end

endmodule
